// File: rtl/neopix_pkg.sv
// neopix_pkg: frame FSM states, default WS2812 timing and pixel width.
// Defining NEOPIX_RGBW_EN selects 32-bit RGBW pixels instead of 24-bit RGB.
package neopix_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, SEND, LATCH} state_e;
    localparam int T0H_DEF   = 20;
    localparam int T1H_DEF   = 40;
    localparam int TBIT_DEF  = 63;
    localparam int RESET_DEF = 3000;
    localparam int PRIME_CYC = 3;
`ifdef NEOPIX_RGBW_EN
    localparam int BITS_PER_PIX = 32;
`else
    localparam int BITS_PER_PIX = 24;
`endif
endpackage

// File: rtl/neopix_bit_timer.sv
// neopix_bit_timer: one WS2812 bit period; high for T0H/T1H clocks, low for the rest.
// A go_i on the bit_done_o clock restarts immediately, so consecutive bits have no gap.
module neopix_bit_timer import neopix_pkg::*; #(
    parameter int T0H_CYC  = T0H_DEF,
    parameter int T1H_CYC  = T1H_DEF,
    parameter int TBIT_CYC = TBIT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic go_i,
    input  logic bit_i,
    output logic dout_o,
    output logic bit_done_o
);
    localparam int CW = $clog2(TBIT_CYC);
    logic [CW-1:0] cnt_q, cnt_d;
    logic act_q, act_d, bit_q, bit_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            act_q <= 1'b0;
            bit_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            act_q <= act_d;
            bit_q <= bit_d;
        end
    end

    always_comb begin
        bit_done_o = act_q && cnt_q == CW'(TBIT_CYC - 1);
        dout_o     = act_q && cnt_q < (bit_q ? CW'(T1H_CYC) : CW'(T0H_CYC));
        act_d      = go_i ? 1'b1 : bit_done_o ? 1'b0 : act_q;
        bit_d      = go_i ? bit_i : bit_q;
        cnt_d      = go_i ? '0 : act_q ? cnt_q + 1'b1 : cnt_q;
    end
endmodule

// File: rtl/neopix_frame_tx.sv
// neopix_frame_tx: streams num_pix_i RAM words as a WS2812 waveform, then latches low.
// Pixel width follows NEOPIX_RGBW_EN (24-bit RGB when undefined, 32-bit RGBW when defined).
module neopix_frame_tx import neopix_pkg::*; #(
    parameter int T0H_CYC   = T0H_DEF,
    parameter int T1H_CYC   = T1H_DEF,
    parameter int TBIT_CYC  = TBIT_DEF,
    parameter int RESET_CYC = RESET_DEF,
    parameter int AW        = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [9:0]    num_pix_i,
    output logic [AW-1:0] rdaddr_o,
    input  logic [31:0]   q_i,
    output logic          dout_o,
    output logic          busy_o,
    output logic          done_o
);
    localparam int LW  = $clog2(RESET_CYC);
    localparam int SHL = 32 - BITS_PER_PIX;
    state_e        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [9:0]    num_q, num_d, pix_q, pix_d, num_c;
    logic [4:0]    bidx_q, bidx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   shift_q, shift_d, shadow_q, shadow_d;
    logic [1:0]    fd_q, fd_d;
    logic          busy_q, busy_d, done_q, done_d, go, go_bit, bit_done;

    assign num_c    = num_pix_i > 10'd512 ? 10'd512 : num_pix_i;
    assign rdaddr_o = addr_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

    neopix_bit_timer #(.T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC), .TBIT_CYC(TBIT_CYC)) u_bit (
        .clk_i(clk_i), .rst_i(rst_i), .go_i(go), .bit_i(go_bit),
        .dout_o(dout_o), .bit_done_o(bit_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            pix_q    <= '0;
            bidx_q   <= '0;
            addr_q   <= '0;
            shift_q  <= '0;
            shadow_q <= '0;
            fd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            pix_q    <= pix_d;
            bidx_q   <= bidx_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            shadow_q <= shadow_d;
            fd_q     <= fd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // fd_q counts down from each pixel start to the clock the next word is on q_i
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        pix_d    = pix_q;
        bidx_d   = bidx_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        shadow_d = fd_q == 2'd1 ? q_i : shadow_q;
        fd_d     = fd_q != 2'd0 ? fd_q - 2'd1 : fd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        go       = 1'b0;
        go_bit   = 1'b0;
        case (state_q)
            IDLE: if (start_i && !done_q) begin
                num_d   = num_c;
                addr_d  = '0;
                busy_d  = 1'b1;
                cnt_d   = '0;
                state_d = num_c == 10'd0 ? LATCH : PRIME;
            end
            PRIME: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LW'(PRIME_CYC - 1)) begin
                    cnt_d   = '0;
                    shift_d = q_i << SHL;
                    go      = 1'b1;
                    go_bit  = q_i[BITS_PER_PIX-1];
                    addr_d  = addr_q + AW'(1);
                    fd_d    = 2'd3;
                    bidx_d  = '0;
                    pix_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: if (bit_done) begin
                if (bidx_q == 5'(BITS_PER_PIX - 1)) begin
                    if (pix_q == num_q - 10'd1) begin
                        cnt_d   = '0;
                        state_d = LATCH;
                    end else begin
                        go      = 1'b1;
                        go_bit  = shadow_q[BITS_PER_PIX-1];
                        shift_d = shadow_q << SHL;
                        bidx_d  = '0;
                        pix_d   = pix_q + 10'd1;
                        addr_d  = addr_q + AW'(1);
                        fd_d    = 2'd3;
                    end
                end else begin
                    go      = 1'b1;
                    go_bit  = shift_q[30];
                    shift_d = shift_q << 1;
                    bidx_d  = bidx_q + 5'd1;
                end
            end
            LATCH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LW'(RESET_CYC - 1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_neopix_frame_tx.sv
// tb_neopix_frame_tx: randomized frames against a pulse-measuring reference of the WS2812 waveform.
// Timing is scaled down so a full 512-pixel frame stays short.
module tb_neopix_frame_tx;
    localparam int T0H = 2, T1H = 3, TBIT = 4, RST_C = 50, AW = 9;
`ifdef NEOPIX_RGBW_EN
    localparam int BITS = 32;
`else
    localparam int BITS = 24;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [9:0] num = '0;
    logic [AW-1:0] rdaddr;
    logic [31:0] q;
    logic dout, busy, done;
    logic [31:0] mem [512];
    logic [AW-1:0] a1;
    int cyc = 0, vec = 0, errs = 0;
    int rs[$], hw[$], ad[$];
    int hcnt = 0, dcnt = 0, dcyc = -1, bfall = -1;
    logic pd = 1'b0, pb = 1'b0;
    logic [AW-1:0] pa = '0;

    always #5 clk = ~clk;

    neopix_frame_tx #(.T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .RESET_CYC(RST_C), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .num_pix_i(num), .rdaddr_o(rdaddr),
        .q_i(q), .dout_o(dout), .busy_o(busy), .done_o(done)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        a1 <= rdaddr;
        q <= mem[a1];
    end

    always @(negedge clk) begin
        if (dout && !pd) begin rs.push_back(cyc); hcnt = 1; end
        else if (dout) hcnt++;
        if (!dout && pd) hw.push_back(hcnt);
        if (done) begin dcnt++; dcyc = cyc; end
        if (pb && !busy) bfall = cyc;
        if (rdaddr != pa) ad.push_back(int'(rdaddr));
        pd = dout; pb = busy; pa = rdaddr;
    end

    function automatic int expw(int p, int b);
        logic [31:0] w;
        w = mem[9'(p)];
        return w[BITS-1-b] ? T1H : T0H;
    endfunction

    task automatic clr();
        rs.delete(); hw.delete(); ad.delete();
        dcnt = 0; dcyc = -1; bfall = -1;
    endtask

    task automatic run_frame(input int n, input int mid, input bit at_done, output bit to, output int sc, output int pa0);
        int lim;
        clr();
        pa0 = int'(rdaddr);
        lim = (n > 512 ? 512 : n) * BITS * TBIT + RST_C + 100;
        @(posedge clk); #1;
        num = 10'(n); start = 1'b1; sc = cyc;
        @(posedge clk); #1;
        to = 1'b1;
        for (int i = 0; i < lim && to; i++) begin
            start = (i == mid);
            if (i == mid) num = 10'd1;
            if (done) begin to = 1'b0; start = at_done; end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (dout !== 1'b0) begin errs++; $display("FAIL reset_dout got %0b want 0", dout); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", busy); end
        vec++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %0b want 0", done); end
        vec++; if (rdaddr !== '0) begin errs++; $display("FAIL reset_rdaddr got %0d want 0", rdaddr); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bit to; int sc, pa0, bad, first, last; logic [31:0] sw;
        mem[0] = 32'h00A50F01; mem[1] = $urandom;
        run_frame(1, -1, 1'b0, to, sc, pa0);
        vec++; if (to !== 1'b0) begin errs++; $display("FAIL single_timeout got %0b want 0", to); end
        vec++; if (rs.size() !== BITS) begin errs++; $display("FAIL single_bits got %0d want %0d", rs.size(), BITS); end
        sw = '0; bad = 0;
        foreach (hw[i]) begin
            sw = {sw[30:0], hw[i] == T1H};
            if (i < BITS && hw[i] != expw(0, i)) bad++;
        end
        vec++; if (sw !== 32'h00A50F01) begin errs++; $display("FAIL single_payload got %h want 00a50f01", sw); end
        vec++; if (bad !== 0) begin errs++; $display("FAIL single_highs got %0d bad want 0", bad); end
        bad = 0;
        for (int i = 1; i < rs.size(); i++) if (rs[i] - rs[i-1] != TBIT) bad++;
        vec++; if (bad !== 0) begin errs++; $display("FAIL single_period got %0d bad want 0", bad); end
        first = rs.size() > 0 ? rs[0] : -1;
        last = rs.size() > 0 ? rs[rs.size()-1] : -1;
        vec++; if (first !== sc + 4) begin errs++; $display("FAIL single_first_rise got %0d want %0d", first, sc + 4); end
        vec++; if (dcnt !== 1) begin errs++; $display("FAIL single_done_count got %0d want 1", dcnt); end
        vec++; if (dcyc - last !== TBIT + RST_C) begin errs++; $display("FAIL single_latch got %0d want %0d", dcyc - last, TBIT + RST_C); end
        vec++; if (bfall !== dcyc) begin errs++; $display("FAIL single_busy_fall got %0d want %0d", bfall, dcyc); end
    endtask

    task automatic test_zero();
        bit to; int sc, pa0;
        run_frame(0, -1, 1'b0, to, sc, pa0);
        vec++; if (to !== 1'b0) begin errs++; $display("FAIL zero_timeout got %0b want 0", to); end
        vec++; if (rs.size() !== 0) begin errs++; $display("FAIL zero_pulses got %0d want 0", rs.size()); end
        vec++; if (dcyc - sc !== RST_C + 1) begin errs++; $display("FAIL zero_latch got %0d want %0d", dcyc - sc, RST_C + 1); end
        vec++; if (dcnt !== 1) begin errs++; $display("FAIL zero_done_count got %0d want 1", dcnt); end
    endtask

    task automatic test_start_ignored();
        bit to; int sc, pa0, bad, last; bit seen;
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        run_frame(3, 30, 1'b1, to, sc, pa0);
        vec++; if (to !== 1'b0) begin errs++; $display("FAIL ign_timeout got %0b want 0", to); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL ign_done_start got busy %0b want 0", busy); end
        vec++; if (rs.size() !== 3 * BITS) begin errs++; $display("FAIL ign_bits got %0d want %0d", rs.size(), 3 * BITS); end
        bad = 0;
        foreach (hw[i]) if (i < 3 * BITS && hw[i] != expw(i / BITS, i % BITS)) bad++;
        vec++; if (bad !== 0) begin errs++; $display("FAIL ign_highs got %0d bad want 0", bad); end
        last = rs.size() > 0 ? rs[rs.size()-1] : -1;
        vec++; if (dcyc - last !== TBIT + RST_C) begin errs++; $display("FAIL ign_latch got %0d want %0d", dcyc - last, TBIT + RST_C); end
        num = 10'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL ign_next_start got busy %0b want 1", busy); end
        seen = 1'b0;
        for (int i = 0; i < RST_C + 20 && !seen; i++) begin
            seen = done;
            @(posedge clk); #1;
        end
        vec++; if (seen !== 1'b1) begin errs++; $display("FAIL ign_next_done got %0b want 1", seen); end
    endtask

    task automatic test_reset_mid();
        bit to; int sc, pa0, k;
        for (int i = 0; i < 6; i++) mem[i] = $urandom;
        clr();
        @(posedge clk); #1;
        num = 10'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5 * BITS * TBIT && rs.size() < 3 * BITS + 6; i++) @(posedge clk);
        #1;
        vec++; if (rs.size() !== 3 * BITS + 6) begin errs++; $display("FAIL rstmid_reach got %0d want %0d", rs.size(), 3 * BITS + 6); end
        rst = 1'b1;
        @(posedge clk); #1;
        vec++; if (dout !== 1'b0) begin errs++; $display("FAIL rstmid_dout got %0b want 0", dout); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        rst = 1'b0;
        k = rs.size();
        repeat (5 * BITS * TBIT + RST_C) @(posedge clk);
        #1;
        vec++; if (dcnt !== 0) begin errs++; $display("FAIL rstmid_no_done got %0d want 0", dcnt); end
        vec++; if (rs.size() !== k) begin errs++; $display("FAIL rstmid_quiet got %0d want %0d", rs.size(), k); end
        mem[0] = $urandom;
        run_frame(1, -1, 1'b0, to, sc, pa0);
        vec++; if (to !== 1'b0) begin errs++; $display("FAIL rstmid_restart got timeout %0b want 0", to); end
        vec++; if (rs.size() !== BITS) begin errs++; $display("FAIL rstmid_restart_bits got %0d want %0d", rs.size(), BITS); end
    endtask

    task automatic test_rgbw();
        bit to; int sc, pa0, f, l;
        mem[0] = 32'h80000001;
        run_frame(1, -1, 1'b0, to, sc, pa0);
        f = hw.size() > 0 ? hw[0] : -1;
        l = hw.size() > 0 ? hw[hw.size()-1] : -1;
        vec++; if (hw.size() !== BITS) begin errs++; $display("FAIL w_bits got %0d want %0d", hw.size(), BITS); end
        vec++; if (f !== expw(0, 0)) begin errs++; $display("FAIL w_first got %0d want %0d", f, expw(0, 0)); end
        vec++; if (l !== expw(0, BITS - 1)) begin errs++; $display("FAIL w_last got %0d want %0d", l, expw(0, BITS - 1)); end
    endtask

    task automatic test_full();
        bit to; int sc, pa0, bad, n; int e[$]; logic [31:0] w;
        for (int i = 0; i < 512; i++) begin
            w = $urandom;
            mem[i] = {w[31:24], 24'(i * 66311 + 1193046)};
        end
        n = $urandom_range(513, 1023);
        run_frame(n, -1, 1'b0, to, sc, pa0);
        vec++; if (to !== 1'b0) begin errs++; $display("FAIL full_timeout got %0b want 0", to); end
        vec++; if (rs.size() !== 512 * BITS) begin errs++; $display("FAIL full_bits got %0d want %0d", rs.size(), 512 * BITS); end
        bad = 0;
        foreach (hw[i]) if (i < 512 * BITS && hw[i] != expw(i / BITS, i % BITS)) bad++;
        vec++; if (bad !== 0) begin errs++; $display("FAIL full_payload got %0d bad want 0", bad); end
        bad = 0;
        for (int i = 1; i < rs.size(); i++) if (rs[i] - rs[i-1] != TBIT) bad++;
        vec++; if (bad !== 0) begin errs++; $display("FAIL full_period got %0d bad want 0", bad); end
        if (pa0 != 0) e.push_back(0);
        for (int k = 1; k <= 512; k++) e.push_back(k % 512);
        bad = 0;
        foreach (e[i]) if (i >= ad.size() || ad[i] != e[i]) bad++;
        vec++; if (ad.size() !== e.size()) begin errs++; $display("FAIL full_addr_count got %0d want %0d", ad.size(), e.size()); end
        vec++; if (bad !== 0) begin errs++; $display("FAIL full_addr_order got %0d bad want 0", bad); end
        vec++; if (dcnt !== 1) begin errs++; $display("FAIL full_done_count got %0d want 1", dcnt); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_zero();
        test_start_ignored();
        test_reset_mid();
        test_rgbw();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
